// File: rtl/fft_bf_sdf.sv
// Radix-2^2 single-delay-feedback butterfly stage (BFI when BF_TYPE=0, BFII with -j rotation when BF_TYPE=1).
// Optional halving of the outputs (round half up) when the macro FFT_BF_SCALE_EN is defined.
module fft_bf_sdf #(
    parameter int DATA_WIDTH = 25,
    parameter int DELAY_LEN  = 512,
    parameter int BF_TYPE    = 0,
`ifdef FFT_BF_SCALE_EN
    localparam int OW = DATA_WIDTH
`else
    localparam int OW = DATA_WIDTH + 1
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic signed [OW-1:0]         z_re_o,
    output logic signed [OW-1:0]         z_im_o
);

    localparam int L  = $clog2(DELAY_LEN);
    localparam int W1 = DATA_WIDTH + 1;
    localparam int CW = L + 2;
    localparam int AW = (L > 0) ? L : 1;

    logic [CW-1:0]        ctr, ctr_nxt;
    logic [AW-1:0]        wr_ptr;
    logic                 sel, rot, primed;
    logic signed [W1-1:0] xe_re, xe_im, a_re, a_im;
    logic signed [W1-1:0] d_re, d_im, out_re, out_im, push_re, push_im;
    logic signed [OW-1:0] zn_re, zn_im;
    logic signed [W1-1:0] mem_re [DELAY_LEN];
    logic signed [W1-1:0] mem_im [DELAY_LEN];

    // The low counter bits double as the circular-buffer pointer, so the oldest entry sits at wr_ptr.
    if (L > 0) begin : g_ptr
        assign wr_ptr = ctr[AW-1:0];
    end else begin : g_ptr_single
        assign wr_ptr = '0;
    end

    assign sel = ctr[L];
    assign rot = (BF_TYPE == 1) && ctr[L] && ctr[L+1];

    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional, so no latch is inferred.
        ctr_nxt = ctr + CW'(1);
        if (BF_TYPE == 0) begin
            ctr_nxt[CW-1] = 1'b0;
        end
    end

    always_comb begin
        xe_re   = W1'(x_re_i);
        xe_im   = W1'(x_im_i);
        a_re    = rot ? xe_im  : xe_re;
        a_im    = rot ? -xe_re : xe_im;
        d_re    = mem_re[wr_ptr];
        d_im    = mem_im[wr_ptr];
        out_re  = sel ? (d_re + a_re) : d_re;
        out_im  = sel ? (d_im + a_im) : d_im;
        push_re = sel ? (d_re - a_re) : a_re;
        push_im = sel ? (d_im - a_im) : a_im;
    end

`ifdef FFT_BF_SCALE_EN
    logic signed [DATA_WIDTH+1:0] rnd_re, rnd_im;

    // Bits [DATA_WIDTH:1] of v+1 are exactly (v+1) >>> 1 truncated to the output width.
    always_comb begin
        rnd_re = (DATA_WIDTH + 2)'(out_re) + (DATA_WIDTH + 2)'(1);
        rnd_im = (DATA_WIDTH + 2)'(out_im) + (DATA_WIDTH + 2)'(1);
        zn_re  = rnd_re[DATA_WIDTH:1];
        zn_im  = rnd_im[DATA_WIDTH:1];
    end
`else
    always_comb begin
        zn_re = out_re;
        zn_im = out_im;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            ctr     <= '0;
            primed  <= 1'b0;
            valid_o <= 1'b0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else begin
            valid_o <= valid_i & primed;
            if (valid_i) begin
                ctr    <= ctr_nxt;
                z_re_o <= zn_re;
                z_im_o <= zn_im;
                if (wr_ptr == AW'(DELAY_LEN - 1)) begin
                    primed <= 1'b1;
                end
            end
        end
    end

    if (DELAY_LEN <= 32) begin : g_dly_reg
        always_ff @(posedge clk_i) begin
            if (rst) begin
                for (int i = 0; i < DELAY_LEN; i++) begin
                    mem_re[i] <= '0;
                    mem_im[i] <= '0;
                end
            end else if (valid_i) begin
                mem_re[wr_ptr] <= push_re;
                mem_im[wr_ptr] <= push_im;
            end
        end
    end else begin : g_dly_ram
        // NOTE: a deep delay line is left unreset so it maps to RAM; primed hides its stale contents.
        always_ff @(posedge clk_i) begin
            if (valid_i) begin
                mem_re[wr_ptr] <= push_re;
                mem_im[wr_ptr] <= push_im;
            end
        end
    end

endmodule
